i2c_reg_ctrl: RTL and testbench

Register-file controller that sits on top of the byte-level I2C slave and sequences its strobe/stall interface. It implements the usual "pointer-then-data" protocol: the first byte of a write transaction sets the register pointer, following bytes write registers with auto-increment, and read transactions stream registers from the pointer. A fabric-side host port shares the same register file, with I2C taking priority on collisions; a host lock holds off the I2C master using address clock-stretch.

---
 rtl/i2c_reg_ctrl.sv | 123 ++++++++++++
 tb/tb_i2c_reg_ctrl.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_ctrl.sv
// Register-file controller layered on a byte-level I2C slave: pointer-then-data
// writes, auto-increment streaming reads, and a fabric host port sharing the registers.
module i2c_reg_ctrl #(
   parameter int ADDR_W = 4,
   parameter logic [(2**ADDR_W)-1:0] RO_MASK = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i2c_addr_match_stb,
   input  logic              i2c_stop_stb,
   input  logic              i2c_error_stb,
   input  logic [7:0]        i2c_data_rd,
   input  logic              i2c_data_rd_valid_stb,
   input  logic              i2c_data_wr_finish_stb,
   output logic [7:0]        i2c_data_wr,
   output logic              i2c_addr_stall,
   output logic              i2c_data_rd_stall,
   output logic              i2c_data_wr_stall,
   input  logic              host_lock,
   input  logic              host_wr_en,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [7:0]        host_wdata,
   output logic [7:0]        host_rdata,
   output logic              host_wr_collision,
   output logic              reg_i2c_wr_stb,
   output logic [ADDR_W-1:0] reg_i2c_wr_addr,
   output logic [ADDR_W-1:0] ptr,
   output logic [7:0]        err_count
);

   localparam int NUM_REGS = 2**ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PTR,
      S_DATA
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [ADDR_W-1:0] ptr_next;
   logic              i2c_wr_en;
   logic              host_hit;
   logic [7:0]        regs [NUM_REGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         ptr   <= '0;
      end else begin
         state <= next_state;
         ptr   <= ptr_next;
      end
   end

   // Bus-level events (error, stop, address) override the byte-driven transition.
   always_comb begin
      next_state = state;
      ptr_next   = ptr;
      i2c_wr_en  = 1'b0;
      if (i2c_data_rd_valid_stb && (state == S_PTR)) begin
         ptr_next   = i2c_data_rd[ADDR_W-1:0];
         next_state = S_DATA;
      end else if (i2c_data_rd_valid_stb && (state == S_DATA)) begin
         i2c_wr_en = !RO_MASK[ptr];
         ptr_next  = ptr + ADDR_W'(1);
      end else if (i2c_data_wr_finish_stb) begin
         ptr_next = ptr + ADDR_W'(1);
      end
      if (i2c_error_stb || i2c_stop_stb) begin
         next_state = S_IDLE;
      end else if (i2c_addr_match_stb) begin
         next_state = S_PTR;
      end
   end

   assign host_hit = host_wr_en && i2c_wr_en && (host_addr == ptr);

   // The I2C write is placed last so it wins if both target one index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (host_wr_en && !host_hit) begin
            regs[host_addr] <= host_wdata;
         end
         if (i2c_wr_en) begin
            regs[ptr] <= i2c_data_rd;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i2c_data_wr       <= '0;
         i2c_data_rd_stall <= 1'b0;
         i2c_data_wr_stall <= 1'b0;
         host_rdata        <= '0;
         host_wr_collision <= 1'b0;
         reg_i2c_wr_stb    <= 1'b0;
         reg_i2c_wr_addr   <= '0;
         err_count         <= '0;
      end else begin
         i2c_data_wr       <= regs[ptr];
         i2c_data_rd_stall <= i2c_data_rd_valid_stb;
         i2c_data_wr_stall <= i2c_data_wr_finish_stb;
         host_rdata        <= regs[host_addr];
         host_wr_collision <= host_hit;
         reg_i2c_wr_stb    <= i2c_wr_en;
         if (i2c_wr_en) begin
            reg_i2c_wr_addr <= ptr;
         end
         if (i2c_error_stb && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

   assign i2c_addr_stall = host_lock;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Self-checking bench for i2c_reg_ctrl; register-write strobes are logged by a
// monitor and matched against an expected-address queue filled as bytes are driven.
`timescale 1ns/1ps
module tb_i2c_reg_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i2c_addr_match_stb = 1'b0;
   logic       i2c_stop_stb = 1'b0;
   logic       i2c_error_stb = 1'b0;
   logic [7:0] i2c_data_rd = 8'h00;
   logic       i2c_data_rd_valid_stb = 1'b0;
   logic       i2c_data_wr_finish_stb = 1'b0;
   logic [7:0] i2c_data_wr;
   logic       i2c_addr_stall;
   logic       i2c_data_rd_stall;
   logic       i2c_data_wr_stall;
   logic       host_lock = 1'b0;
   logic       host_wr_en = 1'b0;
   logic [3:0] host_addr = 4'h0;
   logic [7:0] host_wdata = 8'h00;
   logic [7:0] host_rdata;
   logic       host_wr_collision;
   logic       reg_i2c_wr_stb;
   logic [3:0] reg_i2c_wr_addr;
   logic [3:0] ptr;
   logic [7:0] err_count;

   int total = 0;
   int bad = 0;

   logic [3:0] exp_q[$];
   logic [3:0] obs_addr [64];
   int         obs_wr = 0;
   int         obs_rd = 0;

   i2c_reg_ctrl #(.ADDR_W(4), .RO_MASK(16'h0004)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .i2c_addr_match_stb(i2c_addr_match_stb),
      .i2c_stop_stb(i2c_stop_stb),
      .i2c_error_stb(i2c_error_stb),
      .i2c_data_rd(i2c_data_rd),
      .i2c_data_rd_valid_stb(i2c_data_rd_valid_stb),
      .i2c_data_wr_finish_stb(i2c_data_wr_finish_stb),
      .i2c_data_wr(i2c_data_wr),
      .i2c_addr_stall(i2c_addr_stall),
      .i2c_data_rd_stall(i2c_data_rd_stall),
      .i2c_data_wr_stall(i2c_data_wr_stall),
      .host_lock(host_lock),
      .host_wr_en(host_wr_en),
      .host_addr(host_addr),
      .host_wdata(host_wdata),
      .host_rdata(host_rdata),
      .host_wr_collision(host_wr_collision),
      .reg_i2c_wr_stb(reg_i2c_wr_stb),
      .reg_i2c_wr_addr(reg_i2c_wr_addr),
      .ptr(ptr),
      .err_count(err_count)
   );

   always #50 clk = ~clk;

   // Monitor only records strobes; the owning test matches them against exp_q.
   always @(negedge clk) begin
      if (rst_n && reg_i2c_wr_stb) begin
         obs_addr[obs_wr % 64] <= reg_i2c_wr_addr;
         obs_wr <= obs_wr + 1;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task send_byte(input logic [7:0] b);
      i2c_data_rd = b;
      i2c_data_rd_valid_stb = 1'b1;
      idle(1);
      i2c_data_rd_valid_stb = 1'b0;
   endtask

   task pulse_addr;
      i2c_addr_match_stb = 1'b1;
      idle(1);
      i2c_addr_match_stb = 1'b0;
   endtask

   task pulse_stop;
      i2c_stop_stb = 1'b1;
      idle(1);
      i2c_stop_stb = 1'b0;
   endtask

   task pulse_finish;
      i2c_data_wr_finish_stb = 1'b1;
      idle(1);
      i2c_data_wr_finish_stb = 1'b0;
   endtask

   task host_write(input logic [3:0] a, input logic [7:0] d);
      host_addr = a;
      host_wdata = d;
      host_wr_en = 1'b1;
      idle(1);
      host_wr_en = 1'b0;
   endtask

   task host_read(input logic [3:0] a, output logic [7:0] d);
      host_addr = a;
      idle(1);
      d = host_rdata;
   endtask

   task test_reset;
      idle(2);
      total++;
      if (ptr !== 4'h0 || err_count !== 8'h00 || i2c_data_wr !== 8'h00 || host_rdata !== 8'h00) begin
         bad++;
         $display("[TB] FAIL reset_values: got ptr=%h err=%h dwr=%h hrd=%h expected all 0", ptr, err_count, i2c_data_wr, host_rdata);
      end
      total++;
      if ({i2c_addr_stall, i2c_data_rd_stall, i2c_data_wr_stall, host_wr_collision, reg_i2c_wr_stb} !== 5'b0) begin
         bad++;
         $display("[TB] FAIL reset_flags: got %b expected 00000",
                  {i2c_addr_stall, i2c_data_rd_stall, i2c_data_wr_stall, host_wr_collision, reg_i2c_wr_stb});
      end
      rst_n = 1'b1;
      idle(1);
   endtask

   task test_write;
      logic [7:0] d;
      logic [3:0] e;
      pulse_addr();
      send_byte(8'h03);
      exp_q.push_back(4'h3);
      send_byte(8'hAA);
      total++;
      if (i2c_data_rd_stall !== 1'b1) begin
         bad++;
         $display("[TB] FAIL write_rd_stall: got %b expected 1", i2c_data_rd_stall);
      end
      exp_q.push_back(4'h4);
      send_byte(8'hBB);
      pulse_stop();
      total++;
      if (i2c_data_rd_stall !== 1'b0) begin
         bad++;
         $display("[TB] FAIL write_rd_stall_release: got %b expected 0", i2c_data_rd_stall);
      end
      total++;
      if (ptr !== 4'h5) begin
         bad++;
         $display("[TB] FAIL write_ptr: got %h expected 5", ptr);
      end
      send_byte(8'h77);
      total++;
      if (ptr !== 4'h5) begin
         bad++;
         $display("[TB] FAIL write_idle_ignore: got ptr %h expected 5", ptr);
      end
      host_read(4'h3, d);
      total++;
      if (d !== 8'hAA) begin
         bad++;
         $display("[TB] FAIL write_reg3: got %h expected aa", d);
      end
      host_read(4'h4, d);
      total++;
      if (d !== 8'hBB) begin
         bad++;
         $display("[TB] FAIL write_reg4: got %h expected bb", d);
      end
      total++;
      if (obs_wr - obs_rd != exp_q.size()) begin
         bad++;
         $display("[TB] FAIL write_stb_count: got %0d expected %0d", obs_wr - obs_rd, exp_q.size());
      end
      while (exp_q.size() > 0 && obs_rd < obs_wr) begin
         e = exp_q.pop_front();
         total++;
         if (obs_addr[obs_rd % 64] !== e) begin
            bad++;
            $display("[TB] FAIL write_stb_addr: got %h expected %h", obs_addr[obs_rd % 64], e);
         end
         obs_rd++;
      end
      exp_q.delete();
      obs_rd = obs_wr;
   endtask

   task test_read;
      host_write(4'hF, 8'h11);
      host_write(4'h0, 8'h22);
      pulse_addr();
      send_byte(8'h0F);
      pulse_addr();
      total++;
      if (i2c_data_wr !== 8'h11 || ptr !== 4'hF) begin
         bad++;
         $display("[TB] FAIL read_first: got dwr=%h ptr=%h expected dwr=11 ptr=f", i2c_data_wr, ptr);
      end
      pulse_finish();
      total++;
      if (i2c_data_wr_stall !== 1'b1 || ptr !== 4'h0) begin
         bad++;
         $display("[TB] FAIL read_wrap: got stall=%b ptr=%h expected stall=1 ptr=0", i2c_data_wr_stall, ptr);
      end
      idle(1);
      total++;
      if (i2c_data_wr_stall !== 1'b0 || i2c_data_wr !== 8'h22) begin
         bad++;
         $display("[TB] FAIL read_second: got stall=%b dwr=%h expected stall=0 dwr=22", i2c_data_wr_stall, i2c_data_wr);
      end
      pulse_finish();
      total++;
      if (i2c_data_wr_stall !== 1'b1 || ptr !== 4'h1) begin
         bad++;
         $display("[TB] FAIL read_ptr: got stall=%b ptr=%h expected stall=1 ptr=1", i2c_data_wr_stall, ptr);
      end
      pulse_stop();
      total++;
      if (obs_wr != obs_rd) begin
         bad++;
         $display("[TB] FAIL read_no_stb: got %0d strobes expected 0", obs_wr - obs_rd);
      end
      obs_rd = obs_wr;
   endtask

   task test_read_only;
      logic [7:0] d;
      pulse_addr();
      send_byte(8'h02);
      send_byte(8'h55);
      pulse_stop();
      total++;
      if (ptr !== 4'h3) begin
         bad++;
         $display("[TB] FAIL ro_ptr: got %h expected 3", ptr);
      end
      host_read(4'h2, d);
      total++;
      if (d !== 8'h00) begin
         bad++;
         $display("[TB] FAIL ro_protect: got %h expected 00", d);
      end
      total++;
      if (obs_wr != obs_rd) begin
         bad++;
         $display("[TB] FAIL ro_no_stb: got %0d strobes expected 0", obs_wr - obs_rd);
      end
      obs_rd = obs_wr;
      host_write(4'h2, 8'h55);
      host_read(4'h2, d);
      total++;
      if (d !== 8'h55) begin
         bad++;
         $display("[TB] FAIL ro_host_write: got %h expected 55", d);
      end
   endtask

   task test_collision;
      logic [7:0] d;
      logic [3:0] e;
      pulse_addr();
      send_byte(8'h05);
      exp_q.push_back(4'h5);
      i2c_data_rd = 8'h5A;
      i2c_data_rd_valid_stb = 1'b1;
      host_addr = 4'h6;
      host_wdata = 8'h77;
      host_wr_en = 1'b1;
      idle(1);
      i2c_data_rd_valid_stb = 1'b0;
      host_wr_en = 1'b0;
      total++;
      if (host_wr_collision !== 1'b0) begin
         bad++;
         $display("[TB] FAIL coll_diff_index: got %b expected 0", host_wr_collision);
      end
      pulse_addr();
      send_byte(8'h05);
      exp_q.push_back(4'h5);
      i2c_data_rd = 8'h3C;
      i2c_data_rd_valid_stb = 1'b1;
      host_addr = 4'h5;
      host_wdata = 8'h99;
      host_wr_en = 1'b1;
      idle(1);
      i2c_data_rd_valid_stb = 1'b0;
      host_wr_en = 1'b0;
      total++;
      if (host_wr_collision !== 1'b1) begin
         bad++;
         $display("[TB] FAIL coll_pulse: got %b expected 1", host_wr_collision);
      end
      idle(1);
      total++;
      if (host_wr_collision !== 1'b0) begin
         bad++;
         $display("[TB] FAIL coll_pulse_end: got %b expected 0", host_wr_collision);
      end
      pulse_stop();
      host_read(4'h5, d);
      total++;
      if (d !== 8'h3C) begin
         bad++;
         $display("[TB] FAIL coll_i2c_wins: got %h expected 3c", d);
      end
      host_read(4'h6, d);
      total++;
      if (d !== 8'h77) begin
         bad++;
         $display("[TB] FAIL coll_host_parallel: got %h expected 77", d);
      end
      total++;
      if (obs_wr - obs_rd != exp_q.size()) begin
         bad++;
         $display("[TB] FAIL coll_stb_count: got %0d expected %0d", obs_wr - obs_rd, exp_q.size());
      end
      while (exp_q.size() > 0 && obs_rd < obs_wr) begin
         e = exp_q.pop_front();
         total++;
         if (obs_addr[obs_rd % 64] !== e) begin
            bad++;
            $display("[TB] FAIL coll_stb_addr: got %h expected %h", obs_addr[obs_rd % 64], e);
         end
         obs_rd++;
      end
      exp_q.delete();
      obs_rd = obs_wr;
   endtask

   task test_errors;
      pulse_addr();
      send_byte(8'h08);
      i2c_error_stb = 1'b1;
      i2c_stop_stb = 1'b1;
      idle(1);
      i2c_error_stb = 1'b0;
      i2c_stop_stb = 1'b0;
      total++;
      if (err_count !== 8'd1) begin
         bad++;
         $display("[TB] FAIL err_single_inc: got %0d expected 1", err_count);
      end
      send_byte(8'h12);
      total++;
      if (ptr !== 4'h8) begin
         bad++;
         $display("[TB] FAIL err_to_idle: got ptr %h expected 8", ptr);
      end
      i2c_addr_match_stb = 1'b1;
      i2c_stop_stb = 1'b1;
      idle(1);
      i2c_addr_match_stb = 1'b0;
      i2c_stop_stb = 1'b0;
      send_byte(8'h13);
      total++;
      if (ptr !== 4'h8) begin
         bad++;
         $display("[TB] FAIL stop_over_addr: got ptr %h expected 8", ptr);
      end
      i2c_error_stb = 1'b1;
      idle(253);
      total++;
      if (err_count !== 8'd254) begin
         bad++;
         $display("[TB] FAIL err_count_254: got %0d expected 254", err_count);
      end
      idle(1);
      total++;
      if (err_count !== 8'd255) begin
         bad++;
         $display("[TB] FAIL err_count_255: got %0d expected 255", err_count);
      end
      idle(5);
      i2c_error_stb = 1'b0;
      total++;
      if (err_count !== 8'd255) begin
         bad++;
         $display("[TB] FAIL err_saturate: got %0d expected 255", err_count);
      end
      total++;
      if (obs_wr != obs_rd) begin
         bad++;
         $display("[TB] FAIL err_no_stb: got %0d strobes expected 0", obs_wr - obs_rd);
      end
      obs_rd = obs_wr;
   endtask

   task test_lock_and_reset;
      logic [7:0] d;
      host_lock = 1'b1;
      #1;
      total++;
      if (i2c_addr_stall !== 1'b1) begin
         bad++;
         $display("[TB] FAIL lock_stall: got %b expected 1", i2c_addr_stall);
      end
      host_lock = 1'b0;
      #1;
      total++;
      if (i2c_addr_stall !== 1'b0) begin
         bad++;
         $display("[TB] FAIL lock_release: got %b expected 0", i2c_addr_stall);
      end
      idle(1);
      pulse_addr();
      send_byte(8'h09);
      send_byte(8'hEE);
      #60;
      rst_n = 1'b0;
      #1;
      total++;
      if (ptr !== 4'h0 || i2c_data_rd_stall !== 1'b0 || i2c_data_wr_stall !== 1'b0 || reg_i2c_wr_stb !== 1'b0 || err_count !== 8'h00) begin
         bad++;
         $display("[TB] FAIL async_reset: got ptr=%h rds=%b wrs=%b stb=%b err=%0d expected all 0",
                  ptr, i2c_data_rd_stall, i2c_data_wr_stall, reg_i2c_wr_stb, err_count);
      end
      obs_rd = obs_wr;
      idle(1);
      rst_n = 1'b1;
      host_read(4'h9, d);
      total++;
      if (d !== 8'h00) begin
         bad++;
         $display("[TB] FAIL reset_regs: got %h expected 00", d);
      end
   endtask

   initial begin
      $display("[TB] start");
      test_reset();
      test_write();
      test_read();
      test_read_only();
      test_collision();
      test_errors();
      test_lock_and_reset();
      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
